stride_value_predictor: RTL

Per-PC stride value predictor for load results in the MIPS core memory stage. It supersedes the fixed all-zeros predictor with a direct-mapped, tagged table of last value, stride and confidence. It issues a registered prediction one cycle after a request, then tracks one outstanding predicted load. When the D-cache returns the real data, it produces a correct or recover verdict and trains the table.

---
 rtl/stride_value_predictor.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/stride_value_predictor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : stride_value_predictor
//  Purpose  : Per-PC stride value predictor for load results. A direct-mapped,
//             tagged table holds last value, stride and a saturating confidence
//             counter per entry. A prediction is registered one cycle after an
//             accepted request. One predicted load is tracked until the D-cache
//             returns data, which yields a correct/recover verdict and trains
//             the table.
//  Ports    : clk, rst              - clock, async active-high reset
//             pred_req_valid_i/pc_i - prediction request and load PC
//             pred_ready_o          - request accepted when valid is high
//             pred_valid_o/value_o/confident_o - registered prediction pulse
//             d_valid_i/d_data_i    - actual load data for the pending load
//             flush_i               - squash pending load (wins over d_valid_i)
//             done_o/correct_prediction_o/en_recover_o - verdict pulse
//  Revision : 1.0 - initial release
// ============================================================================
module stride_value_predictor #(
  parameter int INDEX_WIDTH    = 6,
  parameter int TAG_WIDTH      = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int CONF_BITS      = 2,
  parameter int CONF_THRESHOLD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pred_req_valid_i,
  input  logic [ADDR_WIDTH-1:0] pred_req_pc_i,
  output logic                  pred_ready_o,
  output logic                  pred_valid_o,
  output logic [DATA_WIDTH-1:0] pred_value_o,
  output logic                  pred_confident_o,
  input  logic                  d_valid_i,
  input  logic [DATA_WIDTH-1:0] d_data_i,
  input  logic                  flush_i,
  output logic                  done_o,
  output logic                  correct_prediction_o,
  output logic                  en_recover_o
);

  localparam int                   ENTRIES  = 1 << INDEX_WIDTH;
  localparam logic [CONF_BITS-1:0] CONF_MAX = {CONF_BITS{1'b1}};
  localparam logic [CONF_BITS-1:0] CONF_THR = CONF_BITS'(CONF_THRESHOLD);

  // Prediction table; only the valid bits need reset.
  logic [ENTRIES-1:0]    valid_q;
  logic [TAG_WIDTH-1:0]  tag_q    [ENTRIES];
  logic [DATA_WIDTH-1:0] last_q   [ENTRIES];
  logic [DATA_WIDTH-1:0] stride_q [ENTRIES];
  logic [CONF_BITS-1:0]  conf_q   [ENTRIES];

  // Single outstanding load.
  logic                   pend_q;
  logic [INDEX_WIDTH-1:0] pend_idx_q;
  logic [TAG_WIDTH-1:0]   pend_tag_q;
  logic                   pend_hit_q;
  logic [DATA_WIDTH-1:0]  pend_pred_q;
  logic                   pend_conf_q;

  // Registered outputs.
  logic                  pred_valid_q;
  logic [DATA_WIDTH-1:0] pred_value_q;
  logic                  pred_conf_q;
  logic                  done_q;
  logic                  correct_q;
  logic                  recover_q;

  logic [INDEX_WIDTH-1:0] req_idx;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic                   accept;
  logic                   resolve;
  logic                   match;

  assign req_idx = pred_req_pc_i[INDEX_WIDTH+1:2];
  assign req_tag = pred_req_pc_i[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2];

  // Word-offset and upper PC bits take no part in indexing or tagging.
  logic unused_pc_lo;
  assign unused_pc_lo = ^pred_req_pc_i[1:0];
  if (ADDR_WIDTH > INDEX_WIDTH + TAG_WIDTH + 2) begin : g_pc_hi_unused
    logic unused_pc_hi;
    assign unused_pc_hi = ^pred_req_pc_i[ADDR_WIDTH-1:INDEX_WIDTH+TAG_WIDTH+2];
  end

  // flush wins over d_valid; a resolve frees the slot for a same-cycle accept.
  assign pred_ready_o = !rst && (!pend_q || d_valid_i || flush_i);
  assign accept       = pred_req_valid_i && pred_ready_o;
  assign resolve      = pend_q && d_valid_i && !flush_i;
  assign match        = (d_data_i == pend_pred_q);

  // Training: next contents of the entry owned by the pending load.
  logic [DATA_WIDTH-1:0] cur_last;
  logic [DATA_WIDTH-1:0] cur_stride;
  logic [CONF_BITS-1:0]  cur_conf;
  logic [DATA_WIDTH-1:0] trn_stride_d;
  logic [CONF_BITS-1:0]  trn_conf_d;

  assign cur_last   = last_q[pend_idx_q];
  assign cur_stride = stride_q[pend_idx_q];
  assign cur_conf   = conf_q[pend_idx_q];

  always_comb begin
    trn_stride_d = '0;
    trn_conf_d   = '0;
    if (pend_hit_q) begin
      if (match) begin
        trn_stride_d = cur_stride;
        trn_conf_d   = (cur_conf == CONF_MAX) ? cur_conf : cur_conf + 1'b1;
      end else begin
        trn_stride_d = d_data_i - cur_last;
      end
    end
  end

  // Lookup with forwarding of a same-cycle training write, so back-to-back
  // loads from one PC observe the freshly trained entry.
  logic                  fwd;
  logic                  e_valid;
  logic [TAG_WIDTH-1:0]  e_tag;
  logic [DATA_WIDTH-1:0] e_last;
  logic [DATA_WIDTH-1:0] e_stride;
  logic [CONF_BITS-1:0]  e_conf;
  logic                  look_hit;
  logic [DATA_WIDTH-1:0] look_pred;
  logic                  look_conf;

  assign fwd       = resolve && (pend_idx_q == req_idx);
  assign e_valid   = fwd ? 1'b1         : valid_q[req_idx];
  assign e_tag     = fwd ? pend_tag_q   : tag_q[req_idx];
  assign e_last    = fwd ? d_data_i     : last_q[req_idx];
  assign e_stride  = fwd ? trn_stride_d : stride_q[req_idx];
  assign e_conf    = fwd ? trn_conf_d   : conf_q[req_idx];
  assign look_hit  = e_valid && (e_tag == req_tag);
  assign look_pred = look_hit ? (e_last + e_stride) : '0;
  assign look_conf = look_hit && (e_conf >= CONF_THR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (resolve) begin
      valid_q[pend_idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resolve) begin
      tag_q[pend_idx_q]    <= pend_tag_q;
      last_q[pend_idx_q]   <= d_data_i;
      stride_q[pend_idx_q] <= trn_stride_d;
      conf_q[pend_idx_q]   <= trn_conf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q       <= 1'b0;
      pend_idx_q   <= '0;
      pend_tag_q   <= '0;
      pend_hit_q   <= 1'b0;
      pend_pred_q  <= '0;
      pend_conf_q  <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_value_q <= '0;
      pred_conf_q  <= 1'b0;
      done_q       <= 1'b0;
      correct_q    <= 1'b0;
      recover_q    <= 1'b0;
    end else begin
      pred_valid_q <= accept;
      pred_value_q <= accept ? look_pred : '0;
      pred_conf_q  <= accept && look_conf;
      done_q       <= resolve;
      correct_q    <= resolve && pend_conf_q && match;
      recover_q    <= resolve && pend_conf_q && !match;
      if (accept) begin
        pend_q      <= 1'b1;
        pend_idx_q  <= req_idx;
        pend_tag_q  <= req_tag;
        pend_hit_q  <= look_hit;
        pend_pred_q <= look_pred;
        pend_conf_q <= look_conf;
      end else if (resolve || flush_i) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign pred_valid_o         = pred_valid_q;
  assign pred_value_o         = pred_value_q;
  assign pred_confident_o     = pred_conf_q;
  assign done_o               = done_q;
  assign correct_prediction_o = correct_q;
  assign en_recover_o         = recover_q;

endmodule
`default_nettype wire
